// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: M-extension decode constants, muldiv FSM states, XLEN.
package riscv_pkg;

  localparam int XLEN = 32;

  // R-type opcode and funct7 that together select the M extension
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // M-extension funct3 encodings
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } md_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes on
// accept, processed one bit per cycle, and the sign is restored in FIXUP.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; operands and sign flag captured on accept
// S_CALC  | 32 shift-add (mul) or restoring shift-subtract (div) steps
// S_FIXUP | optional two's-complement negate, output select, load result
// S_DONE  | one-cycle done / wb_en pulse, then back to S_IDLE
module muldiv_unit
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic            wb_en,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] result
);

  md_state_t state, state_next;

  logic [2:0]  op;
  logic [31:0] mag2;
  logic        neg;
  logic [5:0]  cnt;
  // mul: {partial product high, multiplier shifting out}
  // div: {partial remainder, dividend shifting out / quotient shifting in}
  logic [63:0] acc;

  // accept-time decode, only ever feeds registers
  logic        signed1, signed2;
  logic [31:0] mag1_in, mag2_in;
  logic        neg_in;
  logic        div_by_zero, div_ovf, special;
  logic [31:0] special_result;

  // shared adder/subtractor and step datapath
  logic        is_div;
  logic [32:0] pr;
  logic [32:0] add_a;
  logic [33:0] add_b;
  logic [33:0] sum;
  logic [63:0] acc_step;

  // fixup negator and output select
  logic [63:0] fix_src;
  logic [63:0] fix_val;
  logic [31:0] fix_result;

  // operand signedness, magnitudes, result sign and fast-path detection
  always_comb begin
    signed1 = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
              (funct3 == F3_DIV)  || (funct3 == F3_REM);
    signed2 = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    mag1_in = (signed1 && src1[31]) ? (32'd0 - src1) : src1;
    mag2_in = (signed2 && src2[31]) ? (32'd0 - src2) : src2;

    case (funct3)
      F3_MULH:   neg_in = src1[31] ^ src2[31];
      F3_MULHSU: neg_in = src1[31];
      F3_DIV:    neg_in = src1[31] ^ src2[31];
      F3_REM:    neg_in = src1[31];
      default:   neg_in = 1'b0;
    endcase

    div_by_zero = funct3[2] && (src2 == 32'd0);
    div_ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                  (src1 == 32'h8000_0000) && (src2 == 32'hFFFF_FFFF);
    special     = div_by_zero || div_ovf;

    if (div_by_zero) begin
      special_result = funct3[1] ? src1 : 32'hFFFF_FFFF;
    end else begin
      special_result = funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // one iteration: add multiplicand or trial-subtract divisor on a single adder
  always_comb begin
    is_div = op[2];
    pr     = {acc[63:32], acc[31]};
    add_a  = is_div ? pr : {1'b0, acc[63:32]};
    add_b  = is_div ? ~{2'b00, mag2} : {2'b00, mag2};
    sum    = {1'b0, add_a} + add_b + {33'd0, is_div};

    if (is_div) begin
      // sum[33] set means the trial subtraction went negative: restore
      if (!sum[33]) begin
        acc_step = {sum[31:0], acc[30:0], 1'b1};
      end else begin
        acc_step = {pr[31:0], acc[30:0], 1'b0};
      end
    end else begin
      if (acc[0]) begin
        acc_step = {sum[32:0], acc[31:1]};
      end else begin
        acc_step = {1'b0, acc[63:1]};
      end
    end
  end

  // sign restore and output select
  always_comb begin
    if (op[2]) begin
      fix_src = op[1] ? {32'd0, acc[63:32]} : {32'd0, acc[31:0]};
    end else begin
      fix_src = acc;
    end
    fix_val    = neg ? (~fix_src + 64'd1) : fix_src;
    fix_result = ((op == F3_MUL) || op[2]) ? fix_val[31:0] : fix_val[63:32];
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (cnt == 6'd31) begin
          state_next = S_FIXUP;
        end
      end
      S_FIXUP: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // operand capture, iteration and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op     <= 3'd0;
      rd_out <= 5'd0;
      mag2   <= 32'd0;
      neg    <= 1'b0;
      cnt    <= 6'd0;
      acc    <= 64'd0;
      result <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op     <= funct3;
            rd_out <= rd_in;
            mag2   <= mag2_in;
            neg    <= neg_in;
            cnt    <= 6'd0;
            acc    <= {32'd0, mag1_in};
            if (special) begin
              result <= special_result;
            end
          end
        end
        S_CALC: begin
          cnt <= cnt + 6'd1;
          acc <= acc_step;
        end
        S_FIXUP: begin
          result <= fix_result;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign wb_en = done;

endmodule
